nubus_slave_xfer: RTL and testbench

//  NuBus slave transaction engine: decodes the card's slot space (0xFs000000-0xFsFFFFFF, s = ~id_n),

---
 rtl/nubus_slave_xfer.sv | 218 +++++++++++++++++++++
 tb/tb_nubus_slave_xfer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_slave_xfer.sv
// NuBus slave transaction engine: slot-space decode, valid/ready memory port, ACK + TM status.
// Optional NUBUS_SLAVE_TIMEOUT_EN: abort a stalled memory access with TRY_AGAIN_LATER.
module nubus_slave_xfer #(
  parameter int unsigned MEM_ADDR_W     = 22,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  nub_clkn,
  input  logic                  nub_resetn,
  input  logic [3:0]            id_n,
  input  logic                  start_n,
  input  logic                  ack_n,
  input  logic [1:0]            tm_n,
  input  logic [31:0]           ad_i_n,
  output logic [31:0]           ad_o_n,
  output logic                  ad_oe,
  output logic                  ack_o_n,
  output logic                  ack_oe,
  output logic [1:0]            tm_o_n,
  output logic                  tm_oe,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_MEM, S_ACK} state_t;

  localparam logic [1:0] ST_COMPLETE  = 2'b00;
  localparam logic [1:0] ST_ERROR     = 2'b01;
  localparam logic [1:0] ST_TRY_AGAIN = 2'b11;

  state_t                state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [31:0]           ad_o_n_q, ad_o_n_d;
  logic                  ad_oe_q, ad_oe_d;
  logic                  ack_o_n_q, ack_o_n_d;
  logic                  ack_oe_q, ack_oe_d;
  logic [1:0]            tm_o_n_q, tm_o_n_d;
  logic                  tm_oe_q, tm_oe_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [3:0]            mode;
  logic [21:0]           addr_true;
  logic                  slot_hit;
  logic                  blk_mode;
  logic [3:0]            be_dec;
  logic [31:0]           lane_mask;

`ifdef NUBUS_SLAVE_TIMEOUT_EN
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
  logic [7:0]            tmo_next;
`endif

  logic unused_ok;
  assign unused_ok = ack_n | (TIMEOUT_CYCLES == 32'd0);

  assign mode      = ~{tm_n, ad_i_n[1:0]};
  assign addr_true = ~ad_i_n[23:2];
  assign slot_hit  = ((~ad_i_n[31:24]) == {4'hF, ~id_n});
  assign blk_mode  = (mode[2:0] == 3'b101);
  assign lane_mask = {{8{mem_be_q[3]}}, {8{mem_be_q[2]}}, {8{mem_be_q[1]}}, {8{mem_be_q[0]}}};

  always_comb begin
    be_dec = '0;
    case (mode[2:0])
      3'b000:  be_dec = 4'b0001;
      3'b001:  be_dec = 4'b0010;
      3'b010:  be_dec = 4'b0100;
      3'b011:  be_dec = 4'b1000;
      3'b100:  be_dec = 4'b0011;
      3'b110:  be_dec = 4'b1100;
      3'b111:  be_dec = 4'b1111;
      default: be_dec = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    ad_o_n_d    = ad_o_n_q;
    ad_oe_d     = ad_oe_q;
    ack_o_n_d   = ack_o_n_q;
    ack_oe_d    = ack_oe_q;
    tm_o_n_d    = tm_o_n_q;
    tm_oe_d     = tm_oe_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
    tmo_cnt_d   = '0;
    tmo_next    = tmo_cnt_q + 8'd1;
`endif
    case (state_q)
      S_IDLE: begin
        if (!start_n && slot_hit) begin
          mem_addr_d = MEM_ADDR_W'(addr_true);
          mem_be_d   = be_dec;
          is_read_d  = mode[3];
          if (blk_mode) begin
            ack_oe_d  = 1'b1;
            ack_o_n_d = 1'b0;
            tm_oe_d   = 1'b1;
            tm_o_n_d  = ~ST_ERROR;
            ad_oe_d   = 1'b0;
            state_d   = S_ACK;
          end else if (mode[3]) begin
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            state_d     = S_MEM;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        mem_wdata_d = ~ad_i_n;
        mem_valid_d = 1'b1;
        mem_we_d    = 1'b1;
        state_d     = S_MEM;
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (is_read_q) ad_o_n_d = ~(mem_rdata & lane_mask);
          ack_oe_d  = 1'b1;
          ack_o_n_d = 1'b0;
          tm_oe_d   = 1'b1;
          tm_o_n_d  = ~ST_COMPLETE;
          ad_oe_d   = is_read_q;
          state_d   = S_ACK;
        end
`ifdef NUBUS_SLAVE_TIMEOUT_EN
        // Counter is zero on the entry edge; the abort fires on the edge it would reach the limit.
        else if (tmo_next == 8'(TIMEOUT_CYCLES)) begin
          mem_valid_d = 1'b0;
          ack_oe_d    = 1'b1;
          ack_o_n_d   = 1'b0;
          tm_oe_d     = 1'b1;
          tm_o_n_d    = ~ST_TRY_AGAIN;
          ad_oe_d     = 1'b0;
          state_d     = S_ACK;
        end else begin
          tmo_cnt_d = tmo_next;
        end
`endif
      end
      S_ACK: begin
        ad_oe_d   = 1'b0;
        ack_oe_d  = 1'b0;
        ack_o_n_d = 1'b1;
        tm_oe_d   = 1'b0;
        tm_o_n_d  = 2'b11;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q     <= S_IDLE;
      is_read_q   <= 1'b0;
      ad_o_n_q    <= '1;
      ad_oe_q     <= 1'b0;
      ack_o_n_q   <= 1'b1;
      ack_oe_q    <= 1'b0;
      tm_o_n_q    <= 2'b11;
      tm_oe_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      ad_o_n_q    <= ad_o_n_d;
      ad_oe_q     <= ad_oe_d;
      ack_o_n_q   <= ack_o_n_d;
      ack_oe_q    <= ack_oe_d;
      tm_o_n_q    <= tm_o_n_d;
      tm_oe_q     <= tm_oe_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign ad_o_n    = ad_o_n_q;
  assign ad_oe     = ad_oe_q;
  assign ack_o_n   = ack_o_n_q;
  assign ack_oe    = ack_oe_q;
  assign tm_o_n    = tm_o_n_q;
  assign tm_oe     = tm_oe_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_nubus_slave_xfer.sv
// Directed scoreboard bench for nubus_slave_xfer; slot C, active edge is the falling clock edge.
module tb_nubus_slave_xfer;

  logic        nub_clkn = 1'b1;
  logic        nub_resetn = 1'b0;
  logic [3:0]  id_n = ~4'hC;
  logic        start_n = 1'b1;
  logic        ack_n = 1'b1;
  logic [1:0]  tm_n = 2'b11;
  logic [31:0] ad_i_n = '1;
  logic [31:0] ad_o_n;
  logic        ad_oe, ack_o_n, ack_oe, tm_oe;
  logic [1:0]  tm_o_n;
  logic        mem_valid, mem_we;
  logic [3:0]  mem_be;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b1;

  nubus_slave_xfer #(.MEM_ADDR_W(22), .TIMEOUT_CYCLES(255)) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .id_n(id_n), .start_n(start_n),
    .ack_n(ack_n), .tm_n(tm_n), .ad_i_n(ad_i_n), .ad_o_n(ad_o_n), .ad_oe(ad_oe),
    .ack_o_n(ack_o_n), .ack_oe(ack_oe), .tm_o_n(tm_o_n), .tm_oe(tm_oe),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial forever #5 nub_clkn = ~nub_clkn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [21:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [1:0]  tm;
    logic        ad_oe;
    logic [31:0] ad;
    logic [9:0]  lat;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] be_of(input logic [2:0] m);
    case (m)
      3'd0: return 4'b0001;
      3'd1: return 4'b0010;
      3'd2: return 4'b0100;
      3'd3: return 4'b1000;
      3'd4: return 4'b0011;
      3'd6: return 4'b1100;
      3'd7: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic drive_start(input logic [31:0] addr, input logic [3:0] mode);
    start_n = 1'b0;
    tm_n    = ~mode[3:2];
    ad_i_n  = ~{addr[31:2], mode[1:0]};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ad_oe"}, 64'(ad_oe), 64'(0));
    chk({tag, "_ack_oe"}, 64'(ack_oe), 64'(0));
    chk({tag, "_tm_oe"}, 64'(tm_oe), 64'(0));
    chk({tag, "_ack_o_n"}, 64'(ack_o_n), 64'(1));
    chk({tag, "_tm_o_n"}, 64'(tm_o_n), 64'(2'b11));
    chk({tag, "_ad_o_n"}, 64'(ad_o_n), 64'(32'hFFFF_FFFF));
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_be"}, 64'(mem_be), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  // One complete transaction with mem_ready held high; all checks from the queues.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [3:0] mode,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    req_t r;
    rsp_t s;
    logic blk;
    logic seen_req;
    logic done;
    int   cyc;
    blk = (mode[2:0] == 3'b101);
    if (!blk) begin
      r.we = ~mode[3]; r.be = be_of(mode[2:0]); r.addr = addr[23:2]; r.wdata = wdata;
      req_q.push_back(r);
    end
    s.tm    = blk ? 2'b10 : 2'b11;
    s.ad_oe = mode[3] && !blk;
    s.ad    = ~(rdata & lanes(be_of(mode[2:0])));
    s.lat   = blk ? 10'd1 : (mode[3] ? 10'd2 : 10'd3);
    rsp_q.push_back(s);
    mem_rdata = rdata;
    @(posedge nub_clkn);
    drive_start(addr, mode);
    @(posedge nub_clkn);
    start_n = 1'b1;
    tm_n    = 2'b11;
    ad_i_n  = mode[3] ? 32'hFFFF_FFFF : ~wdata;
    cyc = 1; seen_req = 1'b0; done = 1'b0;
    while (!done && cyc <= 20) begin
      if (mem_valid && !seen_req) begin
        seen_req = 1'b1;
        if (req_q.size() == 0) chk({tag, "_unexpected_mem_valid"}, 64'(mem_valid), 64'(0));
        else begin
          r = req_q.pop_front();
          chk({tag, "_we"}, 64'(mem_we), 64'(r.we));
          chk({tag, "_be"}, 64'(mem_be), 64'(r.be));
          chk({tag, "_addr"}, 64'(mem_addr), 64'(r.addr));
          if (r.we) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(r.wdata));
          chk({tag, "_ad_oe_during_mem"}, 64'(ad_oe), 64'(0));
        end
      end
      if (ack_oe) begin
        s = rsp_q.pop_front();
        done = 1'b1;
        chk({tag, "_latency"}, 64'(cyc), 64'(s.lat));
        chk({tag, "_ack_o_n"}, 64'(ack_o_n), 64'(0));
        chk({tag, "_tm_oe"}, 64'(tm_oe), 64'(1));
        chk({tag, "_tm_o_n"}, 64'(tm_o_n), 64'(s.tm));
        chk({tag, "_ad_oe"}, 64'(ad_oe), 64'(s.ad_oe));
        chk({tag, "_mem_valid_in_ack"}, 64'(mem_valid), 64'(0));
        if (s.ad_oe) chk({tag, "_ad_o_n"}, 64'(ad_o_n), 64'(s.ad));
      end else begin
        @(posedge nub_clkn);
        cyc++;
      end
    end
    if (!done) begin
      chk({tag, "_ack_timeout"}, 64'(ack_oe), 64'(1));
      void'(rsp_q.pop_front());
    end
    chk({tag, "_req_issued"}, 64'(seen_req), 64'(!blk));
    if (!seen_req && !blk) void'(req_q.pop_front());
    @(posedge nub_clkn);
    ad_i_n = '1;
    chk({tag, "_ack_released"}, 64'(ack_oe), 64'(0));
    chk({tag, "_ack_o_n_released"}, 64'(ack_o_n), 64'(1));
    chk({tag, "_ad_oe_released"}, 64'(ad_oe), 64'(0));
    chk({tag, "_tm_oe_released"}, 64'(tm_oe), 64'(0));
  endtask

  initial begin
    rsp_t s;
    int   cyc;

    repeat (2) @(posedge nub_clkn);
    check_reset_outputs("reset");
    nub_resetn = 1'b1;

    xfer("wr_word", 32'hFC00_0000, 4'b0111, 32'h8765_4321, 32'h0);
    xfer("rd_word", 32'hFC00_0000, 4'b1111, 32'h0, 32'h8765_4321);
    xfer("wr_half1", 32'hFC00_0008, 4'b0110, 32'h8765_4321, 32'h0);
    xfer("rd_byte2", 32'hFC00_0014, 4'b1010, 32'h0, 32'h8765_4321);
    xfer("wr_byte0", 32'hFC00_000C, 4'b0000, 32'h1122_3344, 32'h0);
    xfer("rd_half0", 32'hFC00_0020, 4'b1100, 32'h0, 32'hA5A5_C3C3);
    xfer("rd_byte3", 32'hFC00_0030, 4'b1011, 32'h0, 32'hDEAD_BEEF);

    // Other slot: nothing may move.
    @(posedge nub_clkn);
    drive_start(32'hFB00_0000, 4'b1111);
    @(posedge nub_clkn);
    start_n = 1'b1; tm_n = 2'b11; ad_i_n = '1;
    for (int i = 0; i < 4; i++) begin
      chk("other_slot_mem_valid", 64'(mem_valid), 64'(0));
      chk("other_slot_ack_oe", 64'(ack_oe), 64'(0));
      @(posedge nub_clkn);
    end
    chk("other_slot_mem_addr", 64'(mem_addr), 64'(22'hC));

    xfer("blk_read", 32'hFC00_0000, 4'b1101, 32'h0, 32'h0);

    // Memory never ready.
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
    rsp_q.push_back('{tm: 2'b00, ad_oe: 1'b0, ad: 32'hFFFF_FFFF, lat: 10'd256});
`else
    rsp_q.push_back('{tm: 2'b11, ad_oe: 1'b1, ad: ~32'h0BAD_F00D, lat: 10'd301});
`endif
    @(posedge nub_clkn);
    drive_start(32'hFC00_0000, 4'b1111);
    @(posedge nub_clkn);
    start_n = 1'b1; tm_n = 2'b11; ad_i_n = '1;
    cyc = 1;
    while (!ack_oe && cyc < 300) begin
      @(posedge nub_clkn);
      cyc++;
    end
`ifndef NUBUS_SLAVE_TIMEOUT_EN
    chk("stall_no_ack", 64'(ack_oe), 64'(0));
    chk("stall_mem_valid_held", 64'(mem_valid), 64'(1));
    mem_ready = 1'b1;
    @(posedge nub_clkn);
    cyc++;
`endif
    s = rsp_q.pop_front();
    chk("stall_ack_seen", 64'(ack_oe), 64'(1));
    chk("stall_latency", 64'(cyc), 64'(s.lat));
    chk("stall_tm_o_n", 64'(tm_o_n), 64'(s.tm));
    chk("stall_ad_oe", 64'(ad_oe), 64'(s.ad_oe));
    chk("stall_mem_valid", 64'(mem_valid), 64'(0));
    if (s.ad_oe) chk("stall_ad_o_n", 64'(ad_o_n), 64'(s.ad));
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge nub_clkn);
      chk("stall_after_ack_oe", 64'(ack_oe), 64'(0));
      chk("stall_after_mem_valid", 64'(mem_valid), 64'(0));
    end

    // Reset in the middle of a stalled read, with a second START arriving while busy.
    mem_ready = 1'b0;
    @(posedge nub_clkn);
    drive_start(32'hFC00_0040, 4'b1111);
    @(posedge nub_clkn);
    drive_start(32'hFC00_0100, 4'b0111);
    @(posedge nub_clkn);
    start_n = 1'b1; tm_n = 2'b11; ad_i_n = '1;
    chk("busy_start_mem_addr", 64'(mem_addr), 64'(22'h10));
    chk("busy_start_mem_we", 64'(mem_we), 64'(0));
    chk("busy_start_mem_valid", 64'(mem_valid), 64'(1));
    nub_resetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge nub_clkn);
    nub_resetn = 1'b1;
    mem_ready  = 1'b1;
    xfer("post_reset_rd", 32'hFC00_0004, 4'b1111, 32'h0, 32'h1357_9BDF);

    chk("queues_drained", 64'(req_q.size() + rsp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
